// File: rtl/p18_block_hit_pkg.sv
// Shared p18 definitions: playfield geometry, score width and the hit-test FSM encoding.
package p18_block_hit_pkg;

  localparam int P18_NUM_ROWS = 15;
  localparam int P18_NUM_COLS = 13;
  localparam int P18_SCORE_W  = 8;
  localparam int P18_IDX_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEEK  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } p18_state_e;

  // Row index advance with wrap at n rows.
  function automatic logic [P18_IDX_W-1:0] wrap_inc(input logic [P18_IDX_W-1:0] v, input int n);
    return (int'(v) == n - 1) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/p18_block_hit.sv
// Ball/block hit test: rotates the block store to the target row, tests one bit,
// clears it on a hit and keeps the score.
module p18_block_hit
  import p18_block_hit_pkg::*;
#(
  parameter int NUM_ROWS = P18_NUM_ROWS,
  parameter int NUM_COLS = P18_NUM_COLS
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   req,
  input  logic [P18_IDX_W-1:0]   ball_row,
  input  logic [P18_IDX_W-1:0]   ball_col,
  input  logic                   game_reset,
  input  logic [NUM_COLS-1:0]    line,
  output logic [NUM_COLS-1:0]    new_line,
  output logic                   write_line,
  output logic                   next_line,
  output logic                   reset_state,
  output logic                   busy,
  output logic                   done,
  output logic                   hit,
  output logic                   row_cleared,
  output logic [P18_SCORE_W-1:0] score
);

  // Handshake: req is sampled only while busy is low; each accepted req yields
  // exactly one done pulse (unless aborted by game_reset); req while busy is dropped.

  p18_state_e             state_q, state_d;
  logic [P18_IDX_W-1:0]   row_q, row_d;
  logic [P18_IDX_W-1:0]   col_q, col_d;
  logic [P18_IDX_W-1:0]   cur_row_q, cur_row_d;
  logic [P18_SCORE_W-1:0] score_q, score_d;
  logic                   hit_res_q, hit_res_d;
  logic                   clr_res_q, clr_res_d;
  logic                   hit_q, hit_d;
  logic                   row_cleared_q, row_cleared_d;
  logic                   done_q, done_d;

  logic [NUM_COLS-1:0]    col_mask;
  logic [NUM_COLS-1:0]    cleared_line;
  logic                   req_bad;

  assign col_mask     = NUM_COLS'(1) << col_q;
  assign cleared_line = line & ~col_mask;
  assign req_bad      = ({1'b0, ball_row} >= 5'(NUM_ROWS)) || ({1'b0, ball_col} >= 5'(NUM_COLS));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q       <= ST_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      cur_row_q     <= '0;
      score_q       <= '0;
      hit_res_q     <= 1'b0;
      clr_res_q     <= 1'b0;
      hit_q         <= 1'b0;
      row_cleared_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      cur_row_q     <= cur_row_d;
      score_q       <= score_d;
      hit_res_q     <= hit_res_d;
      clr_res_q     <= clr_res_d;
      hit_q         <= hit_d;
      row_cleared_q <= row_cleared_d;
      done_q        <= done_d;
    end
  end

  // Results are staged in *_res and only published on done, so an aborted
  // request never disturbs the visible hit/row_cleared.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    cur_row_d     = cur_row_q;
    score_d       = score_q;
    hit_res_d     = hit_res_q;
    clr_res_d     = clr_res_q;
    hit_d         = hit_q;
    row_cleared_d = row_cleared_q;
    done_d        = 1'b0;
    if (game_reset) begin
      state_d   = ST_IDLE;
      cur_row_d = '0;
      score_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            row_d     = ball_row;
            col_d     = ball_col;
            hit_res_d = 1'b0;
            clr_res_d = 1'b0;
            state_d   = req_bad ? ST_DONE : ST_SEEK;
          end
        end
        ST_SEEK: begin
          if (cur_row_q != row_q) cur_row_d = wrap_inc(cur_row_q, NUM_ROWS);
          else                    state_d   = ST_CHECK;
        end
        ST_CHECK: begin
          hit_res_d = |(line & col_mask);
          state_d   = (|(line & col_mask)) ? ST_WRITE : ST_DONE;
        end
        ST_WRITE: begin
          clr_res_d = (cleared_line == '0);
          score_d   = score_q + 1'b1;
          state_d   = ST_DONE;
        end
        ST_DONE: begin
          done_d        = 1'b1;
          hit_d         = hit_res_q;
          row_cleared_d = clr_res_q;
          state_d       = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    reset_state = game_reset;
    next_line   = 1'b0;
    write_line  = 1'b0;
    if (!game_reset) begin
      next_line  = (state_q == ST_SEEK) && (cur_row_q != row_q);
      write_line = (state_q == ST_WRITE);
    end
    new_line = write_line ? cleared_line : line;
  end

  assign done        = done_q;
  assign hit         = hit_q;
  assign row_cleared = row_cleared_q;
  assign score       = score_q;

endmodule

// File: tb/tb_p18_block_hit.sv
// Bench for p18_block_hit: a behavioural block store answers the bus, a table of
// scenario vectors and a random phase are checked against a playfield model.
module tb_p18_block_hit;

  localparam int NR   = 15;
  localparam int NC   = 13;
  localparam int MAXW = 40;

  logic          clk = 1'b0;
  logic          nRst = 1'b0;
  logic          req = 1'b0;
  logic [3:0]    ball_row = '0;
  logic [3:0]    ball_col = '0;
  logic          game_reset = 1'b0;
  logic [NC-1:0] line;
  logic [NC-1:0] new_line;
  logic          write_line, next_line, reset_state, busy, done, hit, row_cleared;
  logic [7:0]    score;

  int total = 0;
  int bad   = 0;

  p18_block_hit dut (
    .clk(clk), .nRst(nRst), .req(req), .ball_row(ball_row), .ball_col(ball_col),
    .game_reset(game_reset), .line(line), .new_line(new_line), .write_line(write_line),
    .next_line(next_line), .reset_state(reset_state), .busy(busy), .done(done),
    .hit(hit), .row_cleared(row_cleared), .score(score)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [NC-1:0] init_row(input int r);
    case (r)
      0:       return 13'h0AAA;
      2:       return 13'h0001;
      14:      return 13'h1FFF;
      default: return 13'(r * 613 + 97);
    endcase
  endfunction

  // block store responder: rotating row buffer
  logic [NC-1:0] env_mem [NR];
  int            env_ptr;
  assign line = env_mem[env_ptr];

  always @(posedge clk or negedge nRst) begin
    if (!nRst || reset_state) begin
      env_ptr <= 0;
      for (int i = 0; i < NR; i++) env_mem[i] <= init_row(i);
    end else begin
      if (write_line) env_mem[env_ptr] <= new_line;
      if (next_line)  env_ptr <= (env_ptr + 1) % NR;
    end
  end

  // reference playfield, indexed by absolute row number
  logic [NC-1:0] ref_field [NR];
  int            ref_cur;
  int            ref_score;
  logic          ref_hit, ref_clr;

  typedef struct {
    logic [3:0]    row;
    logic [3:0]    col;
    bit            noise;
    int            lat;
    int            nl;
    int            wr;
    logic [NC-1:0] nw;
    logic          hit;
    logic          clr;
    logic [7:0]    score;
  } vec_t;

  typedef struct {
    int            lat;
    int            nl;
    int            wr;
    logic [NC-1:0] nw;
    logic          hit;
    logic          clr;
    logic [7:0]    score;
    int            done_cnt;
    int            idle_at;
    bit            bus_ok;
  } obs_t;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) ref_field[i] = init_row(i);
    ref_cur   = 0;
    ref_score = 0;
  endtask

  task automatic model_req(input logic [3:0] r, input logic [3:0] c, output vec_t e);
    int d;
    e.row = r; e.col = c; e.noise = 1'b0;
    e.nl = 0; e.wr = 0; e.nw = '0; e.hit = 1'b0; e.clr = 1'b0;
    if (int'(r) >= NR || int'(c) >= NC) begin
      e.lat = 1;
    end else begin
      d = (int'(r) - ref_cur + NR) % NR;
      e.nl = d;
      if (ref_field[r][c]) begin
        e.hit = 1'b1;
        e.wr  = 1;
        e.nw  = ref_field[r] & ~(NC'(1) << c);
        ref_field[r] = e.nw;
        e.clr = (e.nw == '0);
        ref_score = (ref_score + 1) % 256;
        e.lat = d + 4;
      end else begin
        e.lat = d + 3;
      end
      ref_cur = int'(r);
    end
    e.score = 8'(ref_score);
    ref_hit = e.hit;
    ref_clr = e.clr;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // driver: called at a falling edge, returns at a falling edge
  task automatic run_req(input logic [3:0] r, input logic [3:0] c, input bit noise,
                         input int exp_lat, output obs_t o);
    int stop_at;
    o.lat = -1; o.nl = 0; o.wr = 0; o.nw = '0; o.hit = 1'b0; o.clr = 1'b0;
    o.score = '0; o.done_cnt = 0; o.idle_at = -1; o.bus_ok = 1'b1;
    stop_at = MAXW;
    req = 1'b1; ball_row = r; ball_col = c;
    @(posedge clk);
    for (int k = 0; k < MAXW && k <= stop_at; k++) begin
      @(negedge clk);
      req = noise && (k < exp_lat) && ($urandom_range(0, 1) == 1);
      if (next_line) o.nl++;
      if (write_line) begin
        o.wr++;
        o.nw = new_line;
      end
      if (write_line && next_line) o.bus_ok = 1'b0;
      if (!write_line && new_line !== line) o.bus_ok = 1'b0;
      if (!busy && o.idle_at < 0) o.idle_at = k;
      if (done) begin
        o.done_cnt++;
        if (o.lat < 0) begin
          o.lat = k; o.hit = hit; o.clr = row_cleared; o.score = score;
          stop_at = k + 1;
        end
      end
    end
    req = 1'b0;
  endtask

  task automatic check_obs(input string tag, input vec_t e, input obs_t o);
    chk({tag, " latency"}, o.lat, e.lat);
    chk({tag, " next_line pulses"}, o.nl, e.nl);
    chk({tag, " write_line pulses"}, o.wr, e.wr);
    if (e.wr > 0) chk({tag, " new_line"}, 32'(o.nw), 32'(e.nw));
    chk({tag, " hit"}, 32'(o.hit), 32'(e.hit));
    chk({tag, " row_cleared"}, 32'(o.clr), 32'(e.clr));
    chk({tag, " score"}, 32'(o.score), 32'(e.score));
    chk({tag, " done count"}, o.done_cnt, 1);
    chk({tag, " busy drop"}, o.idle_at, e.lat);
    chk({tag, " bus rules"}, 32'(o.bus_ok), 1);
  endtask

  vec_t tbl [7];

  initial begin
    vec_t e;
    obs_t o;
    int   cnt;
    logic held_hit;

    tbl[0] = '{row:4'd0,  col:4'd0,  noise:1'b0, lat:3,  nl:0,  wr:0, nw:13'h0000, hit:1'b0, clr:1'b0, score:8'd0};
    tbl[1] = '{row:4'd14, col:4'd12, noise:1'b0, lat:18, nl:14, wr:1, nw:13'h0FFF, hit:1'b1, clr:1'b0, score:8'd1};
    tbl[2] = '{row:4'd2,  col:4'd0,  noise:1'b1, lat:7,  nl:3,  wr:1, nw:13'h0000, hit:1'b1, clr:1'b1, score:8'd2};
    tbl[3] = '{row:4'd2,  col:4'd1,  noise:1'b0, lat:3,  nl:0,  wr:0, nw:13'h0000, hit:1'b0, clr:1'b0, score:8'd2};
    tbl[4] = '{row:4'd15, col:4'd0,  noise:1'b1, lat:1,  nl:0,  wr:0, nw:13'h0000, hit:1'b0, clr:1'b0, score:8'd2};
    tbl[5] = '{row:4'd0,  col:4'd13, noise:1'b1, lat:1,  nl:0,  wr:0, nw:13'h0000, hit:1'b0, clr:1'b0, score:8'd2};
    tbl[6] = '{row:4'd0,  col:4'd1,  noise:1'b1, lat:17, nl:13, wr:1, nw:13'h0AA8, hit:1'b1, clr:1'b0, score:8'd3};

    model_reset();
    ref_hit = 1'b0;
    ref_clr = 1'b0;

    // reset values
    #12;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst hit", 32'(hit), 0);
    chk("rst row_cleared", 32'(row_cleared), 0);
    chk("rst score", 32'(score), 0);
    chk("rst next_line", 32'(next_line), 0);
    chk("rst write_line", 32'(write_line), 0);
    chk("rst reset_state", 32'(reset_state), 0);
    @(negedge clk);
    nRst = 1'b1;

    // table phase: first request lands on the first edge after release
    for (int i = 0; i < 7; i++) begin
      model_req(tbl[i].row, tbl[i].col, e);
      run_req(tbl[i].row, tbl[i].col, tbl[i].noise, tbl[i].lat, o);
      check_obs($sformatf("vec%0d", i), tbl[i], o);
    end

    // game_reset while seeking
    held_hit = hit;
    req = 1'b1; ball_row = 4'((ref_cur + 10) % NR); ball_col = 4'd0;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort seek next_line", 32'(next_line), 1);
    game_reset = 1'b1;
    #1;
    chk("abort reset_state", 32'(reset_state), 1);
    chk("abort next_line forced", 32'(next_line), 0);
    chk("abort write_line forced", 32'(write_line), 0);
    @(negedge clk);
    game_reset = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort score", 32'(score), 0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (done) cnt++;
      @(negedge clk);
    end
    chk("abort no done", cnt, 0);
    chk("abort hit held", 32'(hit), 32'(held_hit));
    model_reset();
    model_req(4'd0, 4'd3, e);
    run_req(4'd0, 4'd3, 1'b0, e.lat, o);
    check_obs("after abort", e, o);

    // game_reset and req together in IDLE
    req = 1'b1; ball_row = 4'd5; ball_col = 4'd0; game_reset = 1'b1;
    #1;
    chk("prio reset_state", 32'(reset_state), 1);
    @(negedge clk);
    req = 1'b0; game_reset = 1'b0;
    chk("prio busy", 32'(busy), 0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (done || next_line || busy) cnt++;
      @(negedge clk);
    end
    chk("prio no activity", cnt, 0);
    model_reset();

    // random phase
    for (int i = 0; i < 30; i++) begin
      logic [3:0] r, c;
      r = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, NR - 1));
      c = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(NC, 15)) : 4'($urandom_range(0, NC - 1));
      model_req(r, c, e);
      run_req(r, c, 1'b1, e.lat, o);
      check_obs($sformatf("rnd%0d", i), e, o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
